// File: rtl/bpi_flash_responder_if.sv
// rtl/bpi_flash_responder_if.sv - BPI flash host/device pin bundle
// Host drives strobes, address and write data; the device returns read data.
interface bpi_flash_responder_if #(
    parameter int ADDR_WD = 26,
    parameter int DATA_WD = 16
);
    logic [ADDR_WD-1:0] flash_addr;
    logic [DATA_WD-1:0] flash_wdata;
    logic               flash_ce;
    logic               flash_we;
    logic               flash_oe;
    logic               flash_adv;
    logic               flash_clk;
    logic [DATA_WD-1:0] flash_rdata;
    logic               flash_rd_oe;
    logic               flash_wait;

    modport master (
        output flash_addr, flash_wdata, flash_ce, flash_we, flash_oe, flash_adv, flash_clk,
        input  flash_rdata, flash_rd_oe, flash_wait
    );

    modport slave (
        input  flash_addr, flash_wdata, flash_ce, flash_we, flash_oe, flash_adv, flash_clk,
        output flash_rdata, flash_rd_oe, flash_wait
    );
endinterface

// File: rtl/bpi_flash_responder.sv
// rtl/bpi_flash_responder.sv - behavioural BPI NOR flash device (buffered program, block erase)
// Optional block locking is enabled by defining BPI_RESP_LOCK_EN.
module bpi_flash_responder #(
    parameter int          ADDR_WD   = 26,
    parameter int          DATA_WD   = 16,
    parameter int          MEM_AW    = 10,
    parameter int          BLK_AW    = 6,
    parameter int          BUF_DEPTH = 32,
    parameter int          PROG_DLY  = 64,
    parameter int          ERASE_DLY = 256,
    parameter int          RD_LAT    = 3,
    parameter logic [15:0] DEV_ID    = 16'h8962
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    bpi_flash_responder_if.slave     flash,
    output logic                     busy
);
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam int BK_WD     = MEM_AW - BLK_AW;
    localparam int BUF_AW    = $clog2(BUF_DEPTH);
    localparam int CNT_WD    = 16;
    localparam int RC_WD     = $clog2(RD_LAT + 1);

    localparam logic [CNT_WD-1:0]  PROG_LAST  = CNT_WD'(PROG_DLY - 1);
    localparam logic [CNT_WD-1:0]  BLK_WORDS  = CNT_WD'(1 << BLK_AW);
    localparam logic [CNT_WD-1:0]  ERASE_LAST = CNT_WD'((1 << BLK_AW) + ERASE_DLY - 1);
    localparam logic [DATA_WD-1:0] BUF_LIMIT  = DATA_WD'(BUF_DEPTH);
    localparam logic [RC_WD-1:0]   RD_LAST    = RC_WD'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_CMD, S_WB_CNT, S_WB_DATA, S_WB_CONF, S_ER_CONF, S_LK_CONF, S_PROG, S_ERASE
    } state_t;
    typedef enum logic [1:0] {M_ARRAY, M_STATUS, M_ID} mode_t;

    state_t state_q, state_d;
    mode_t  mode_q, mode_d;

    logic               we_s1_q, we_s2_q, ce_s1_q, ce_s2_q;
    logic [MEM_AW-1:0]  addr_s1_q, addr_s2_q;
    logic [DATA_WD-1:0] data_s1_q, data_s2_q;
    logic               wr_evt;
    logic [7:0]         cmd;

    logic [2:0]         err_q, err_d;
    logic [BUF_AW-1:0]  wcnt_q, wcnt_d, idx_q, idx_d, buf_widx;
    logic [MEM_AW-1:0]  base_q, base_d, buf_off, prog_addr, mem_waddr;
    logic [BK_WD-1:0]   blk_q, blk_d;
    logic [CNT_WD-1:0]  dly_q, dly_d;
    logic               buf_we, mem_we;
    logic [DATA_WD-1:0] mem_wdata;
    logic               prog_locked, erase_locked, rd_lock;

    logic [RC_WD-1:0]   rd_cnt_q;
    logic               rd_oe_q;
    logic [DATA_WD-1:0] rdata_q, rd_val;
    logic [7:0]         sr;

    // Array holds inverted data so power-up zero contents read back as erased.
    logic [DATA_WD-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WD-1:0] buf_q [BUF_DEPTH];

    logic unused_ok;
    assign unused_ok = &{1'b0, flash.flash_adv, flash.flash_clk, flash.flash_addr[ADDR_WD-1:MEM_AW]};

    assign wr_evt    = we_s1_q && !we_s2_q && !ce_s2_q;
    assign cmd       = data_s2_q[7:0];
    assign busy      = (state_q == S_PROG) || (state_q == S_ERASE);
    assign sr        = {!busy, 1'b0, err_q[2], err_q[1], 2'b00, err_q[0], 1'b0};
    assign buf_off   = addr_s2_q - base_q;
    assign prog_addr = base_q + MEM_AW'(dly_q[BUF_AW-1:0]);

`ifdef BPI_RESP_LOCK_EN
    logic [(1<<BK_WD)-1:0] lock_q, lock_d;
    assign prog_locked  = lock_q[base_q[MEM_AW-1:BLK_AW]];
    assign erase_locked = lock_q[blk_q];
    assign rd_lock      = lock_q[flash.flash_addr[MEM_AW-1:BLK_AW]];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) lock_q <= '1;
        else         lock_q <= lock_d;
    end
`else
    assign prog_locked  = 1'b0;
    assign erase_locked = 1'b0;
    assign rd_lock      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        err_d     = err_q;
        wcnt_d    = wcnt_q;
        base_d    = base_q;
        blk_d     = blk_q;
        idx_d     = idx_q;
        dly_d     = dly_q;
        buf_we    = 1'b0;
        buf_widx  = buf_off[BUF_AW-1:0];
        mem_we    = 1'b0;
        mem_waddr = prog_addr;
        mem_wdata = '0;
`ifdef BPI_RESP_LOCK_EN
        lock_d    = lock_q;
`endif
        case (state_q)
            S_CMD: if (wr_evt) begin
                case (cmd)
                    8'hFF: mode_d = M_ARRAY;
                    8'h70: mode_d = M_STATUS;
                    8'h50: err_d = 3'b000;
                    8'h90: mode_d = M_ID;
                    8'hE8: begin state_d = S_WB_CNT; mode_d = M_STATUS; end
                    8'h20: state_d = S_ER_CONF;
                    8'h60: state_d = S_LK_CONF;
                    default: ;
                endcase
            end
            S_WB_CNT: if (wr_evt) begin
                if (data_s2_q >= BUF_LIMIT) begin
                    err_d[2:1] = 2'b11;
                    state_d    = S_CMD;
                end else begin
                    wcnt_d  = data_s2_q[BUF_AW-1:0];
                    base_d  = addr_s2_q;
                    idx_d   = '0;
                    state_d = S_WB_DATA;
                end
            end
            S_WB_DATA: if (wr_evt) begin
                buf_we = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == wcnt_q) state_d = S_WB_CONF;
            end
            S_WB_CONF: if (wr_evt) begin
                if (cmd == 8'hD0) begin
                    state_d = S_PROG;
                    dly_d   = '0;
                end else begin
                    err_d[2:1] = 2'b11;
                    state_d    = S_CMD;
                end
            end
            S_ER_CONF: if (wr_evt) begin
                if (cmd == 8'hD0) begin
                    state_d = S_ERASE;
                    blk_d   = addr_s2_q[MEM_AW-1:BLK_AW];
                    dly_d   = '0;
                end else begin
                    err_d[2:1] = 2'b11;
                    state_d    = S_CMD;
                end
            end
            S_LK_CONF: if (wr_evt) begin
                state_d = S_CMD;
`ifdef BPI_RESP_LOCK_EN
                if (cmd == 8'h01)      lock_d[addr_s2_q[MEM_AW-1:BLK_AW]] = 1'b1;
                else if (cmd == 8'hD0) lock_d[addr_s2_q[MEM_AW-1:BLK_AW]] = 1'b0;
                else                   err_d[2:1] = 2'b11;
`else
                if (cmd != 8'h01 && cmd != 8'hD0) err_d[2:1] = 2'b11;
`endif
            end
            S_PROG: begin
                if (wr_evt && cmd == 8'h70) mode_d = M_STATUS;
                dly_d = dly_q + 1'b1;
                if (prog_locked) begin
                    err_d[1] = 1'b1;
                    err_d[0] = 1'b1;
                    state_d  = S_CMD;
                    mode_d   = M_STATUS;
                end else begin
                    if (dly_q <= CNT_WD'(wcnt_q)) begin
                        mem_we    = 1'b1;
                        mem_wdata = mem_q[prog_addr] | ~buf_q[dly_q[BUF_AW-1:0]];
                    end
                    if (dly_q >= PROG_LAST && dly_q >= CNT_WD'(wcnt_q)) begin
                        state_d = S_CMD;
                        mode_d  = M_STATUS;
                    end
                end
            end
            S_ERASE: begin
                if (wr_evt && cmd == 8'h70) mode_d = M_STATUS;
                dly_d     = dly_q + 1'b1;
                mem_waddr = {blk_q, dly_q[BLK_AW-1:0]};
                if (erase_locked) begin
                    err_d[2] = 1'b1;
                    err_d[0] = 1'b1;
                    state_d  = S_CMD;
                    mode_d   = M_STATUS;
                end else begin
                    mem_we = (dly_q < BLK_WORDS);
                    if (dly_q == ERASE_LAST) begin
                        state_d = S_CMD;
                        mode_d  = M_STATUS;
                    end
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (mode_q)
            M_ARRAY:  rd_val = ~mem_q[flash.flash_addr[MEM_AW-1:0]];
            M_STATUS: rd_val = DATA_WD'(sr);
            M_ID: begin
                if (flash.flash_addr[BLK_AW-1:0] == BLK_AW'(0))      rd_val = DATA_WD'(16'h0089);
                else if (flash.flash_addr[BLK_AW-1:0] == BLK_AW'(1)) rd_val = DATA_WD'(DEV_ID);
                else if (flash.flash_addr[BLK_AW-1:0] == BLK_AW'(2)) rd_val = DATA_WD'(rd_lock);
                else                                                 rd_val = '0;
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= S_CMD;
            mode_q    <= M_ARRAY;
            err_q     <= '0;
            wcnt_q    <= '0;
            base_q    <= '0;
            blk_q     <= '0;
            idx_q     <= '0;
            dly_q     <= '0;
            we_s1_q   <= 1'b1;
            we_s2_q   <= 1'b1;
            ce_s1_q   <= 1'b1;
            ce_s2_q   <= 1'b1;
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            rd_cnt_q  <= '0;
            rd_oe_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            wcnt_q    <= wcnt_d;
            base_q    <= base_d;
            blk_q     <= blk_d;
            idx_q     <= idx_d;
            dly_q     <= dly_d;
            we_s1_q   <= flash.flash_we;
            we_s2_q   <= we_s1_q;
            ce_s1_q   <= flash.flash_ce;
            ce_s2_q   <= ce_s1_q;
            addr_s1_q <= flash.flash_addr[MEM_AW-1:0];
            addr_s2_q <= addr_s1_q;
            data_s1_q <= flash.flash_wdata;
            data_s2_q <= data_s1_q;
            // Read data goes valid on the RD_LAT-th consecutive cycle of ce/oe low.
            if (!flash.flash_ce && !flash.flash_oe) begin
                if (rd_cnt_q == RD_LAST) begin
                    rd_oe_q <= 1'b1;
                    rdata_q <= rd_val;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                end
            end else begin
                rd_cnt_q <= '0;
                rd_oe_q  <= 1'b0;
                rdata_q  <= '0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        if (buf_we) buf_q[buf_widx] <= data_s2_q;
    end

    assign flash.flash_rdata = rdata_q;
    assign flash.flash_rd_oe = rd_oe_q;
    assign flash.flash_wait  = 1'b0;
endmodule

// File: doc/bpi_flash_responder.md
BPI_FLASH_RESPONDER -- requirements
Module: bpi_flash_responder

Interface
REQ-001 Parameters: ADDR_WD default 26, flash word address width; DATA_WD default 16, data width; MEM_AW default 10, implemented array depth 2^MEM_AW words with address wrap above it; BLK_AW default 6, block size 2^BLK_AW words; BUF_DEPTH default 32, write-buffer words; PROG_DLY default 64, program busy cycles; ERASE_DLY default 256, extra erase busy cycles; RD_LAT default 3, read latency in cycles; DEV_ID default 16'h8962, device code.
REQ-002 Clock and reset: one clock, sys_clk; reset sys_rst is synchronous and active-high.
REQ-003 Ports, all clocked by sys_clk:
- sys_clk, input, 1, clock.
- sys_rst, input, 1, synchronous active-high reset.
- flash_addr, input, ADDR_WD, word address from the host.
- flash_wdata, input, DATA_WD, host write data (host flash_dout).
- flash_ce, flash_we, flash_oe, flash_adv, inputs, 1 each, active-low strobes.
- flash_clk, input, 1, ignored (asynchronous mode only).
- flash_rdata, output, DATA_WD, data to the host (host flash_din).
- flash_rd_oe, output, 1, high while flash_rdata is valid and driven.
- flash_wait, output, 1, constant 0.
- busy, output, 1, high during program or erase.

Function
REQ-004 Strobes are registered with two flops. A write event is a rising edge of the registered flash_we while registered flash_ce is low. Address and data are captured from the previous-cycle registered values.
REQ-005 Read: while flash_ce and flash_oe are both low for RD_LAT consecutive cycles, flash_rd_oe goes to 1 and flash_rdata presents the current read mode data. Either strobe going high clears flash_rd_oe on the next cycle.
REQ-006 Read modes (mode register):
- ARRAY: mem[addr].
- STATUS: {8'h00, SR}.
- ID: offset 0 gives 16'h0089; offset 1 gives DEV_ID; offset 2 gives {15'b0, lock bit of the addressed block}; all other offsets give 0.
REQ-007 Status register bits: SR7 ready (=!busy), SR5 erase error, SR4 program error, SR1 locked-block error; all other bits are 0.
REQ-008 Command FSM states: CMD, WB_CNT, WB_DATA, WB_CONF, ER_CONF, LK_CONF, PROG, ERASE.
REQ-009 In CMD, the data byte of a write event selects the action:
- 0xFF: mode ARRAY.
- 0x70: mode STATUS.
- 0x50: clear SR5, SR4, SR1.
- 0x90: mode ID.
- 0xE8: go to WB_CNT, mode STATUS.
- 0x20: go to ER_CONF.
- 0x60: go to LK_CONF.
- Any other byte: ignored.
REQ-010 WB_CNT: data is N-1. If N > BUF_DEPTH, set SR4 and SR5 and return to CMD. Otherwise latch the base address and go to WB_DATA.
REQ-011 WB_DATA: each write event stores data into buffer[addr - base]. After N words, go to WB_CONF.
REQ-012 WB_CONF: 0xD0 goes to PROG. Any other byte sets SR4 and SR5 and returns to CMD.
REQ-013 PROG: busy is 1. Each buffered word is written as mem[a] = mem[a] AND data (bits clear only), one word per cycle. Busy is held for at least PROG_DLY cycles total, then the FSM returns to CMD with mode STATUS.
REQ-014 ER_CONF: 0xD0 goes to ERASE. Any other byte sets SR4 and SR5 and returns to CMD.
REQ-015 ERASE: writes 16'hFFFF to every word of the addressed block, one word per cycle, then waits ERASE_DLY more cycles, then returns to CMD with mode STATUS.
REQ-016 Write events arriving during PROG or ERASE are ignored, except that 0x70 sets mode STATUS.
REQ-017 Program or erase targeting a locked block sets SR1 and SR4 (program) or SR1 and SR5 (erase), leaves the array unchanged, and holds busy for 1 cycle only.
REQ-018 Array addresses use flash_addr[MEM_AW-1:0]; higher address bits wrap around.

Reset
REQ-019 On sys_rst: mode ARRAY, FSM in CMD, SR = 8'h80, busy=0, flash_rd_oe=0, flash_rdata=0, all delay counters cleared.
REQ-020 The array content is not cleared by reset. Reset during PROG or ERASE aborts the operation immediately; words already written stay written.
REQ-021 Simulation initialises the array to all 16'hFFFF.

Configuration
REQ-022 Macro BPI_RESP_LOCK_EN.
- Defined: one lock bit per block, all set at reset. LK_CONF with 0x01 locks the block and 0xD0 unlocks it. Any other byte sets SR4 and SR5.
- Undefined: no lock bits; LK_CONF accepts 0x01 or 0xD0 as a no-op; ID offset 2 reads 0; SR1 is never set.

Verification
REQ-023 Reset, then read addr 0 in ARRAY mode -> flash_rd_oe rises RD_LAT cycles after ce/oe go low; data 16'hFFFF.
REQ-024 Write 0x90, then read offsets 0 and 1 -> 16'h0089, then 16'h8962; write 0xFF -> array mode restored.
REQ-025 Unlock block 0 (0x60/0xD0), then E8, count 3, data 1111,2222,3333,4444 at addr 0-3, then D0 -> busy for at least 64 cycles; SR reads 8'h80; array reads back the four words.
REQ-026 With BPI_RESP_LOCK_EN defined, program block 1 without unlocking -> SR = 8'h92; array unchanged; 0x50 clears SR to 8'h80.
REQ-027 After REQ-025, erase block 0 (0x20/0xD0) -> addr 0-63 read 16'hFFFF; busy lasts 64+256 cycles.
REQ-028 E8 with count 32 (N=33) -> SR = 8'hB0; FSM back in CMD. Assert sys_rst mid-ERASE -> busy=0 the next cycle; SR = 8'h80.
